// File: rtl/wb_arbiter.sv
// wb_arbiter: two-requester round-robin arbiter feeding a single register-file
// write port.
//
// Ports
//   clk_in, rst_in        clock; asynchronous active-high reset
//   arb_en_in             arbitration enable (low = no grants)
//   reqN_valid_in         requester N has a write-back pending (0 = ALU, 1 = load/multi-cycle)
//   reqN_rd_in            requester N destination register
//   reqN_data_in          requester N write data
//   reqN_ready_out        requester N transfer accepted this cycle (combinational)
//   write_en_out          register file write enable (registered)
//   rd_out, data_out      register file destination / data (registered, hold when idle)
//   conflict_cnt_out      saturating count of cycles with both requesters contending
module wb_arbiter #(
   parameter int DATA_W = 64,
   parameter int CNT_W  = 16
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              arb_en_in,
   input  logic              req0_valid_in,
   input  logic [4:0]        req0_rd_in,
   input  logic [DATA_W-1:0] req0_data_in,
   output logic              req0_ready_out,
   input  logic              req1_valid_in,
   input  logic [4:0]        req1_rd_in,
   input  logic [DATA_W-1:0] req1_data_in,
   output logic              req1_ready_out,
   output logic              write_en_out,
   output logic [4:0]        rd_out,
   output logic [DATA_W-1:0] data_out,
   output logic [CNT_W-1:0]  conflict_cnt_out
);

   localparam int NUM_REQ = 2;

   logic [NUM_REQ-1:0]             req_valid;
   logic [NUM_REQ-1:0][4:0]        req_rd;
   logic [NUM_REQ-1:0][DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]             grant;
   logic                           last_grant;
   logic                           xfer;
   logic                           sel;
   logic                           contention;

   assign req_valid = {req1_valid_in, req0_valid_in};
   assign req_rd    = {req1_rd_in, req0_rd_in};
   assign req_data  = {req1_data_in, req0_data_in};

   // Grant is purely combinational; reset gates it so nothing is accepted
   // (and nothing recorded) while rst_in is high.
   always_comb begin
      grant = '0;
      if (!rst_in && arb_en_in) begin
         if (&req_valid)
            grant = last_grant ? 2'b01 : 2'b10;  // favour the one not served last
         else
            grant = req_valid;
      end
   end

   assign req0_ready_out = grant[0];
   assign req1_ready_out = grant[1];
   assign xfer           = |grant;
   assign sel            = grant[1];
   assign contention     = !rst_in && arb_en_in && (&req_valid);

   // last_grant resets to 1 so the first tie after reset goes to requester 0.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         last_grant       <= 1'b1;
         write_en_out     <= 1'b0;
         rd_out           <= '0;
         data_out         <= '0;
         conflict_cnt_out <= '0;
      end else begin
         if (xfer) begin
            last_grant   <= sel;
            // x0 is hardwired zero: accept the transfer but suppress the write
            write_en_out <= (req_rd[sel] != 5'd0);
            rd_out       <= req_rd[sel];
            data_out     <= req_data[sel];
         end else begin
            write_en_out <= 1'b0;
         end
         if (contention && (conflict_cnt_out != {CNT_W{1'b1}}))
            conflict_cnt_out <= conflict_cnt_out + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b1;
   logic        arb_en_in = 1'b0;
   logic        v0 = 1'b0, v1 = 1'b0;
   logic [4:0]  rd0 = '0, rd1 = '0;
   logic [63:0] d0 = '0, d1 = '0;

   logic        r0, r1, we;
   logic [4:0]  rdo;
   logic [63:0] dout;
   logic [15:0] cnt;
   logic        r0_s, r1_s, we_s;
   logic [4:0]  rdo_s;
   logic [63:0] dout_s;
   logic [1:0]  cnt_s;

   int pass_cnt = 0;
   int total_cnt = 0;

   // reference model state
   int          m_last;
   bit          m_we;
   bit [4:0]    m_rd;
   bit [63:0]   m_data;
   int          m_cnt, m_cnt_s;

   always #5 clk_in = ~clk_in;

   wb_arbiter dut (
      .clk_in(clk_in), .rst_in(rst_in), .arb_en_in(arb_en_in),
      .req0_valid_in(v0), .req0_rd_in(rd0), .req0_data_in(d0), .req0_ready_out(r0),
      .req1_valid_in(v1), .req1_rd_in(rd1), .req1_data_in(d1), .req1_ready_out(r1),
      .write_en_out(we), .rd_out(rdo), .data_out(dout), .conflict_cnt_out(cnt)
   );

   wb_arbiter #(.DATA_W(64), .CNT_W(2)) dut_s (
      .clk_in(clk_in), .rst_in(rst_in), .arb_en_in(arb_en_in),
      .req0_valid_in(v0), .req0_rd_in(rd0), .req0_data_in(d0), .req0_ready_out(r0_s),
      .req1_valid_in(v1), .req1_rd_in(rd1), .req1_data_in(d1), .req1_ready_out(r1_s),
      .write_en_out(we_s), .rd_out(rdo_s), .data_out(dout_s), .conflict_cnt_out(cnt_s)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_last = 1; m_we = 0; m_rd = '0; m_data = '0; m_cnt = 0; m_cnt_s = 0;
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_we"}, we, 0);
      chk({tag, "_rd"}, rdo, 0);
      chk({tag, "_data"}, dout, 0);
      chk({tag, "_cnt"}, cnt, 0);
      chk({tag, "_cnt_s"}, cnt_s, 0);
      chk({tag, "_r0"}, r0, 0);
      chk({tag, "_r1"}, r1, 0);
   endtask

   // One clock of stimulus: drive, check readies against the model, clock,
   // advance the model, check the registered outputs.
   task automatic cycle(input bit en, input bit a_v, input bit [4:0] a_rd, input bit [63:0] a_d,
                        input bit b_v, input bit [4:0] b_rd, input bit [63:0] b_d);
      int gnt;
      arb_en_in = en; v0 = a_v; rd0 = a_rd; d0 = a_d; v1 = b_v; rd1 = b_rd; d1 = b_d;
      #1;
      if (!en)             gnt = -1;
      else if (a_v && b_v) gnt = 1 - m_last;
      else if (a_v)        gnt = 0;
      else if (b_v)        gnt = 1;
      else                 gnt = -1;
      chk("ready0", r0, gnt == 0);
      chk("ready1", r1, gnt == 1);
      @(posedge clk_in);
      if (gnt >= 0) begin
         m_last = gnt;
         m_rd   = (gnt == 0) ? a_rd : b_rd;
         m_data = (gnt == 0) ? a_d : b_d;
         m_we   = (m_rd != 0);
      end else begin
         m_we = 0;
      end
      if (en && a_v && b_v) begin
         m_cnt   = (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
         m_cnt_s = (m_cnt_s < 3) ? m_cnt_s + 1 : m_cnt_s;
      end
      #1;
      chk("write_en", we, m_we);
      chk("rd_out", rdo, m_rd);
      chk("data_out", dout, m_data);
      chk("conflict_cnt", cnt, m_cnt);
      chk("conflict_cnt_sat", cnt_s, m_cnt_s);
   endtask

   task automatic do_reset();
      arb_en_in = 1; v0 = 1; v1 = 1;
      rst_in = 1;
      #1;
      chk_zero_outputs("rst_async");
      @(posedge clk_in);
      #1;
      chk_zero_outputs("rst_held");
      #1 rst_in = 0;
      model_reset();
   endtask

   initial begin
      model_reset();

      // single requester, basic latency
      do_reset();
      cycle(1, 1, 5'd5, 64'hA5, 0, 5'd0, 64'h0);
      chk("single_we", we, 1);
      chk("single_rd", rdo, 5);
      chk("single_data", dout, 64'hA5);

      // four-cycle tie: 0,1,0,1
      do_reset();
      for (int i = 0; i < 4; i++) begin
         cycle(1, 1, 5'd1, 64'h100 + i, 1, 5'd2, 64'h200 + i);
         chk("tie_rd", rdo, (i % 2 == 0) ? 1 : 2);
      end
      chk("tie_cnt4", cnt, 4);
      chk("tie_cnt_sat3", cnt_s, 3);
      cycle(1, 1, 5'd1, 64'h1, 1, 5'd2, 64'h2);
      chk("tie_cnt5", cnt, 5);
      chk("tie_cnt_sat_held", cnt_s, 3);

      // rd=0 accepted but not written
      cycle(1, 0, 5'd3, 64'h3, 1, 5'd0, 64'hFF);
      chk("x0_we", we, 0);

      // disabled for three cycles, then first tie goes to req0
      for (int i = 0; i < 3; i++) cycle(0, 1, 5'd7, 64'h7, 1, 5'd8, 64'h8);
      chk("dis_cnt", cnt, 5);
      cycle(1, 1, 5'd7, 64'h77, 1, 5'd8, 64'h88);
      chk("reen_rd", rdo, 7);

      // back-to-back single-requester writes, no bubble
      for (int i = 0; i < 4; i++) begin
         cycle(1, 0, 5'd0, 64'h0, 1, 5'(10 + i), 64'hC0 + i);
         chk("b2b_we", we, 1);
      end

      // reset between edges while a write is being presented
      cycle(1, 1, 5'd9, 64'hDEAD, 0, 5'd0, 64'h0);
      chk("pre_rst_we", we, 1);
      #2 rst_in = 1;
      arb_en_in = 1; v0 = 1; v1 = 1;
      #1;
      chk_zero_outputs("mid_rst");
      model_reset();
      #2 rst_in = 0;
      cycle(1, 1, 5'd4, 64'h44, 1, 5'd6, 64'h66);
      chk("post_rst_tie_rd", rdo, 4);

      // randomized traffic against the model
      for (int i = 0; i < 300; i++) begin
         bit en, a_v, b_v;
         bit [4:0] a_rd, b_rd;
         en   = ($urandom_range(0, 7) != 0);
         a_v  = 1'($urandom_range(0, 1));
         b_v  = 1'($urandom_range(0, 1));
         a_rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         b_rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         cycle(en, a_v, a_rd, {$urandom, $urandom}, b_v, b_rd, {$urandom, $urandom});
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter: DATA_W, default 64, width of write-back data.
REQ-002 Parameter: CNT_W, default 16, width of conflict counter.
REQ-003 clk_in  input  1  single clock; all state updates on rising edge.
REQ-004 rst_in  input  1  reset, asynchronous, active-high.
REQ-005 arb_en_in  input  1  arbitration enable; low = no grants issued.
REQ-006 req0_valid_in  input  1  requester 0 (ALU path) has a write-back.
REQ-007 req0_rd_in  input  5  requester 0 destination register number.
REQ-008 req0_data_in  input  DATA_W  requester 0 write data.
REQ-009 req0_ready_out  output  1  requester 0 transfer accepted this cycle.
REQ-010 req1_valid_in / req1_rd_in / req1_data_in / req1_ready_out  same widths and meanings for requester 1 (load/multi-cycle path).
REQ-011 write_en_out  output  1  register file write enable.
REQ-012 rd_out  output  5  register file destination number.
REQ-013 data_out  output  DATA_W  register file write data.
REQ-014 conflict_cnt_out  output  CNT_W  saturating count of contention cycles.

Function
REQ-015 Transfer on requester N SHALL occur in a cycle where reqN_valid_in and reqN_ready_out are both 1.
REQ-016 reqN_ready_out SHALL be combinational from current valids, arb_en_in and last-grant state; at most one ready high per cycle.
REQ-017 arb_en_in=0: both ready outputs SHALL be 0.
REQ-018 arb_en_in=1, exactly one valid: that requester's ready SHALL be 1.
REQ-019 arb_en_in=1, both valid: ready SHALL go to the requester not granted most recently (round-robin).
REQ-020 last_grant register SHALL update to the granted requester index on every transfer, else hold.
REQ-021 Write port is always-accepting; no backpressure from register file.
REQ-022 Latency: a transfer in cycle T SHALL appear on rd_out/data_out in cycle T+1, registered.
REQ-023 write_en_out in T+1 SHALL be 1 iff a transfer occurred in T and transferred rd != 0.
REQ-024 Transfer with rd = 0 SHALL be accepted (ready=1) but produce write_en_out=0 (x0 hardwired zero).
REQ-025 No transfer in T: write_en_out=0 in T+1; rd_out/data_out SHALL hold previous values.
REQ-026 Back-to-back transfers SHALL sustain one write per cycle with no bubble.
REQ-027 conflict_cnt_out SHALL increment by 1 each cycle where arb_en_in=1 and both valids=1.
REQ-028 conflict_cnt_out SHALL saturate at 2^CNT_W-1, never wrap.
REQ-029 Requester holding valid without ready SHALL be served within 2 cycles of contention (no starvation).
REQ-030 Valid/rd/data changes while not ready SHALL NOT be captured.

Reset
REQ-031 rst_in=1 SHALL immediately force write_en_out=0, rd_out=0, data_out=0, conflict_cnt_out=0, last_grant=1, independent of clk_in.
REQ-032 While rst_in=1, ready outputs SHALL be 0; no transfer is recorded.
REQ-033 Reset asserted mid-stream SHALL discard the registered write; after deassertion first tie SHALL grant requester 0.

Verification
REQ-034 Reset, then req0 valid rd=5 data=0xA5 alone -> req0_ready=1; next cycle write_en=1, rd_out=5, data_out=0xA5.
REQ-035 Both valid for 4 cycles (rd0=1, rd1=2) after reset -> grants 0,1,0,1; writes rd 1,2,1,2 one cycle later; conflict_cnt_out=4.
REQ-036 req1 valid rd=0 data=0xFF -> req1_ready=1; next cycle write_en=0.
REQ-037 arb_en_in=0 with both valid 3 cycles -> no ready, write_en=0, conflict_cnt_out unchanged; re-enable -> req0 granted first if last grant was 1.
REQ-038 CNT_W=2, 5 contention cycles -> conflict_cnt_out=3 held.
REQ-039 Assert rst_in between clock edges during write_en=1 -> outputs zero without clock edge; post-reset tie grants req0.
